// File: rtl/dual_issue_fetch_queue.sv
// Instruction queue between fetch and the dual-issue decoder.
// A circular buffer of {instr, pc} takes one entry per cycle. The two oldest
// entries are presented as a pair, and one or two entries pop per cycle.
// The read side is combinational from the head entries; there is no
// enqueue-to-output bypass.
//
// Handshake semantics:
//   - Enqueue: an entry is taken on a rising edge when enq_v_i & enq_ready_o
//     & !flush_i. enq_ready_o depends only on registered occupancy, so a full
//     queue refuses an entry even in a cycle where it pops.
//   - Dequeue: when deq_ready_i & v0_o, slot 0 is consumed. Slot 1 is also
//     consumed when v1_o & !do_single_issue_i.
module dual_issue_fetch_queue #(
  parameter int els_p        = 8,
  parameter int data_width_p = 32,
  parameter int pc_width_p   = 22
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      flush_i,
  input  logic                      enq_v_i,
  output logic                      enq_ready_o,
  input  logic [data_width_p-1:0]   enq_instr_i,
  input  logic [pc_width_p-1:0]     enq_pc_i,
  output logic [data_width_p-1:0]   instr0_o,
  output logic [data_width_p-1:0]   instr1_o,
  output logic [pc_width_p-1:0]     pc0_o,
  output logic [pc_width_p-1:0]     pc1_o,
  output logic                      v0_o,
  output logic                      v1_o,
  input  logic                      deq_ready_i,
  input  logic                      do_single_issue_i,
  output logic [$clog2(els_p):0]    count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0]     full_lp = cnt_w_lp'(els_p);
  localparam logic [data_width_p-1:0] nop_lp  = data_width_p'(32'h0000_0013);

  logic [ptr_w_lp-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]     rd_ptr_p1;
  logic [cnt_w_lp-1:0]     count_q, count_d;
  logic [data_width_p-1:0] instr_mem_q [els_p];
  logic [pc_width_p-1:0]   pc_mem_q    [els_p];
  logic                    pair_contig;
  logic                    enq_fire;
  logic [1:0]              pop_n;

  // Head-of-queue presentation: slot outputs and occupancy-based handshakes.
  always_comb begin
    rd_ptr_p1   = rd_ptr_q + ptr_w_lp'(1);
    enq_ready_o = (count_q != full_lp);
    v0_o        = (count_q != '0);
    // The PC comparison wraps at pc_width_p bits. A fetch-side jump breaks the pair.
    pair_contig = (pc_mem_q[rd_ptr_p1] == pc_mem_q[rd_ptr_q] + pc_width_p'(1));
    v1_o        = (count_q >= cnt_w_lp'(2)) & pair_contig;
    instr0_o    = v0_o ? instr_mem_q[rd_ptr_q]  : nop_lp;
    pc0_o       = v0_o ? pc_mem_q[rd_ptr_q]     : '0;
    instr1_o    = v1_o ? instr_mem_q[rd_ptr_p1] : nop_lp;
    pc1_o       = v1_o ? pc_mem_q[rd_ptr_p1]    : '0;
    count_o     = count_q;
  end

  // Pop/enqueue decisions and next pointer/occupancy state; flush wins.
  always_comb begin
    pop_n = 2'd0;
    if (deq_ready_i && v0_o) begin
      pop_n = (v1_o && !do_single_issue_i) ? 2'd2 : 2'd1;
    end
    enq_fire = enq_v_i & enq_ready_o & ~flush_i;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + ptr_w_lp'(pop_n);
      wr_ptr_d = wr_ptr_q + ptr_w_lp'(enq_fire);
      count_d  = count_q + cnt_w_lp'(enq_fire) - cnt_w_lp'(pop_n);
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are not reset because invalid slots are masked.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      instr_mem_q[wr_ptr_q] <= enq_instr_i;
      pc_mem_q[wr_ptr_q]    <= enq_pc_i;
    end
  end

`ifndef SYNTHESIS
  // Structural invariants on occupancy, popping and refused enqueues.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (count_q <= full_lp) else $error("count exceeds depth");
      assert (cnt_w_lp'(pop_n) <= count_q) else $error("pop exceeds count");
      if (enq_v_i && !enq_ready_o && !flush_i) begin
        assert (wr_ptr_d == wr_ptr_q) else $error("refused enqueue moved wr_ptr");
      end
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Self-checking bench for dual_issue_fetch_queue. A queue-based reference
// model predicts the slot outputs, occupancy and ready on every cycle.
module tb_dual_issue_fetch_queue;

  localparam int els_p = 8;
  localparam int dw_p  = 32;
  localparam int pw_p  = 22;
  localparam int ew_p  = dw_p + pw_p;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic             flush_i, enq_v_i, enq_ready_o;
  logic [dw_p-1:0]  enq_instr_i, instr0_o, instr1_o;
  logic [pw_p-1:0]  enq_pc_i, pc0_o, pc1_o;
  logic             v0_o, v1_o, deq_ready_i, do_single_issue_i;
  logic [3:0]       count_o;

  int checks = 0;
  int errors = 0;

  // Model state: each entry is {pc, instr}, oldest entry first.
  logic [ew_p-1:0] exp_q[$];

  dual_issue_fetch_queue #(.els_p(els_p), .data_width_p(dw_p), .pc_width_p(pw_p)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
    .enq_v_i(enq_v_i), .enq_ready_o(enq_ready_o),
    .enq_instr_i(enq_instr_i), .enq_pc_i(enq_pc_i),
    .instr0_o(instr0_o), .instr1_o(instr1_o), .pc0_o(pc0_o), .pc1_o(pc1_o),
    .v0_o(v0_o), .v1_o(v1_o), .deq_ready_i(deq_ready_i),
    .do_single_issue_i(do_single_issue_i), .count_o(count_o)
  );

  // Clock and reset.
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model view of the head pair.
  function automatic logic m_v1();
    logic [pw_p-1:0] p0, p1;
    if (exp_q.size() < 2) return 1'b0;
    p0 = exp_q[0][ew_p-1:dw_p];
    p1 = exp_q[1][ew_p-1:dw_p];
    return p1 == pw_p'(p0 + 1);
  endfunction

  task automatic check_outputs();
    logic v0;
    logic v1;
    v0 = exp_q.size() >= 1;
    v1 = m_v1();
    check("v0", v0_o, v0);
    check("v1", v1_o, v1);
    check("count", count_o, exp_q.size());
    check("enq_ready", enq_ready_o, exp_q.size() != els_p);
    check("pc0", pc0_o, v0 ? exp_q[0][ew_p-1:dw_p] : 0);
    check("instr0", instr0_o, v0 ? exp_q[0][dw_p-1:0] : 32'h13);
    check("pc1", pc1_o, v1 ? exp_q[1][ew_p-1:dw_p] : 0);
    check("instr1", instr1_o, v1 ? exp_q[1][dw_p-1:0] : 32'h13);
  endtask

  task automatic drive(input logic fl, input logic ev, input logic [pw_p-1:0] pc,
                       input logic dr, input logic si);
    flush_i           = fl;
    enq_v_i           = ev;
    enq_pc_i          = pc;
    enq_instr_i       = $urandom;
    deq_ready_i       = dr;
    do_single_issue_i = si;
  endtask

  // One clock: check outputs, advance the model from the driven inputs, pass the edge.
  task automatic step();
    int pop;
    bit fire;
    check_outputs();
    pop  = 0;
    fire = enq_v_i && (exp_q.size() != els_p) && !flush_i;
    if (deq_ready_i && exp_q.size() >= 1) pop = (m_v1() && !do_single_issue_i) ? 2 : 1;
    @(posedge clk_i);
    #1;
    if (flush_i) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < pop; i++) void'(exp_q.pop_front());
      if (fire) exp_q.push_back({enq_pc_i, enq_instr_i});
    end
  endtask

  task automatic enq(input logic [pw_p-1:0] pc);
    drive(1'b0, 1'b1, pc, 1'b0, 1'b0);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step();
    end
    check("drained", count_o, 0);
  endtask

  initial begin
    int idx;
    logic [pw_p-1:0] last_pc;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset_n_i = 1'b0;
    #12;
    check("rst_v0", v0_o, 0);
    check("rst_count", count_o, 0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    #1;
    check("rst_ready", enq_ready_o, 1);

    // Fill to full with no dequeue, then try a refused enqueue.
    for (int i = 0; i < 8; i++) enq(pw_p'(32'h100 + i));
    check("fill_ready", enq_ready_o, 0);
    check("fill_count", count_o, 8);
    check("fill_pc0", pc0_o, 22'h100);
    check("fill_pc1", pc1_o, 22'h101);
    check("fill_v1", v1_o, 1);
    enq(22'h3ff);
    check("full_refuse", count_o, 8);

    // Dual pop the full queue.
    for (int k = 0; k < 4; k++) begin
      check("dual_pc0", pc0_o, 22'h100 + 22'(2 * k));
      check("dual_count", count_o, 8 - 2 * k);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step();
    end
    check("dual_end_v0", v0_o, 0);
    check("dual_end_count", count_o, 0);

    // Single issue followed by a dual pop, then a lone entry.
    for (int i = 0; i < 3; i++) enq(pw_p'(32'h200 + i));
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step();
    check("single_pc0", pc0_o, 22'h201);
    check("single_count", count_o, 2);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step();
    check("pair_count", count_o, 0);
    enq(22'h210);
    check("lone_v1", v1_o, 0);
    check("lone_instr1", instr1_o, 32'h13);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step();
    check("lone_count", count_o, 0);

    // Non-contiguous pair.
    enq(22'h300);
    enq(22'h340);
    check("noncontig_v1", v1_o, 0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step();
    check("noncontig_pc0", pc0_o, 22'h340);
    check("noncontig_count", count_o, 1);
    drain();

    // Stream 20 sequential PCs while popping up to two per cycle.
    idx = 0;
    for (int c = 0; c < 80 && (idx < 20 || exp_q.size() != 0); c++) begin
      bit will_fire;
      drive(1'b0, idx < 20, pw_p'(32'h400 + idx), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0);
      will_fire = enq_v_i && exp_q.size() != els_p;
      step();
      check("stream_cnt_le_full", count_o <= 8, 1);
      if (will_fire) idx++;
    end
    check("stream_all_in", idx, 20);
    drain();

    // Random mix: discontinuities, stalls, single issue and occasional flush.
    last_pc = 22'h3ffff0;
    for (int c = 0; c < 400; c++) begin
      logic [pw_p-1:0] pc;
      pc = ($urandom_range(0, 5) == 0) ? pw_p'($urandom) : pw_p'(last_pc + 1);
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, pc,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
      if (enq_v_i && !flush_i && exp_q.size() != els_p) last_pc = pc;
      step();
    end
    drain();

    // Flush with a same-cycle enqueue.
    for (int i = 0; i < 5; i++) enq(pw_p'(32'h500 + i));
    check("preflush_count", count_o, 5);
    drive(1'b1, 1'b1, 22'h600, 1'b1, 1'b0);
    step();
    check("flush_count", count_o, 0);
    check("flush_v0", v0_o, 0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step();
    check("flush_still_empty", count_o, 0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) enq(pw_p'(32'h700 + i));
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_v0", v0_o, 0);
    check("async_count", count_o, 0);
    exp_q.delete();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    for (int i = 0; i < 4; i++) enq(pw_p'(32'h800 + i));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
